// File: rtl/store_pkg.sv
// Shared types and helpers for the store write-back unit: size codes,
// store-buffer entry layout and the byte-enable lookup.
package store_pkg;

  localparam int XLEN  = 64;
  localparam int IDX_W = 16;  // room for word indices of any practical DEPTH

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [7:0]       be;
    logic [XLEN-1:0]  data;
  } store_entry_t;

  function automatic logic [7:0] be_lookup(input size_e sz);
    logic [7:0] be;
    case (sz)
      SZ_B:    be = 8'h01;
      SZ_H:    be = 8'h03;
      SZ_W:    be = 8'h0F;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Synchronous FIFO used as the store buffer; head entry is visible
// combinationally on dout so the drain can write it in the same cycle.
module store_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  buf_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = buf_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) buf_mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/store_wb_unit.sv
// Store write-back unit: checks stores, formats byte lanes, buffers them and
// drains one per cycle into a 64-bit-word data memory with a registered read port.
module store_wb_unit
  import store_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [63:0]     st_addr,
  input  logic [63:0]     st_data,
  input  logic [1:0]      st_size,
  input  logic            mem_busy,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [63:0]     rd_data,
  output logic            empty,
  output logic            st_err,
  output logic [7:0]      err_cnt
);

  localparam int EW = $bits(store_entry_t);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  size_e         sz;
  logic [2:0]    off;
  logic          misaligned;
  logic          out_of_range;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          ready_en_reg;
  logic          st_err_reg;
  logic [7:0]    err_cnt_reg;
  logic [63:0]   rd_data_reg;
  store_entry_t  push_entry;
  store_entry_t  head;
  logic [CW-1:0] unused_fifo_count;
  logic          unused_idx;
  logic [63:0]   mem [DEPTH];

  assign sz  = size_e'(st_size);
  assign off = st_addr[2:0];

  always_comb begin
    misaligned = 1'b0;
    case (sz)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = st_addr[0];
      SZ_W:    misaligned = |st_addr[1:0];
      default: misaligned = |st_addr[2:0];
    endcase
  end

  assign out_of_range = (st_addr[XLEN-1:3] >= (XLEN-3)'(DEPTH));
  assign accept       = st_valid && st_ready;
  assign push         = accept && !misaligned && !out_of_range;
  assign pop          = !empty && !mem_busy;

  assign push_entry.idx  = IDX_W'(st_addr[AW+2:3]);
  assign push_entry.be   = be_lookup(sz) << off;
  assign push_entry.data = st_data << {off, 3'b000};

  // ready_en keeps st_ready low until the first edge after reset release.
  assign st_ready = ready_en_reg && !fifo_full;
  assign st_err   = st_err_reg;
  assign err_cnt  = err_cnt_reg;
  assign rd_data  = rd_data_reg;
  assign unused_idx = ^head.idx[IDX_W-1:AW];

  store_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (empty),
    .count (unused_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
      st_err_reg   <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      st_err_reg   <= accept && (misaligned || out_of_range);
      if (accept && (misaligned || out_of_range) && err_cnt_reg != 8'hFF)
        err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      for (int b = 0; b < 8; b++) begin
        if (head.be[b]) mem[head.idx[AW-1:0]][b*8 +: 8] <= head.data[b*8 +: 8];
      end
    end
  end

  // Read sees pre-write contents when it collides with a drain write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[rd_addr];
  end

endmodule

// File: tb/tb_store_wb_unit.sv
// Self-checking bench for store_wb_unit: directed scenarios plus random stores
// checked against a byte-addressed reference memory.
module tb_store_wb_unit;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [63:0]   st_addr;
  logic [63:0]   st_data;
  logic [1:0]    st_size;
  logic          mem_busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic          empty;
  logic          st_err;
  logic [7:0]    err_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] model_mem  [DEPTH];
  logic [63:0] model_mask [DEPTH];
  int          model_errs = 0;

  always #5 clk = ~clk;

  store_wb_unit #(.DEPTH(DEPTH), .FIFO_DEPTH(4), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_size  (st_size),
    .mem_busy (mem_busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .empty    (empty),
    .st_err   (st_err),
    .err_cnt  (err_cnt)
  );

  // Reference: a store is legal iff naturally aligned and inside the word array;
  // legal stores write their bytes little-endian starting at the byte address.
  function automatic bit model_illegal(input logic [63:0] addr, input logic [1:0] size);
    int nbytes = 1 << size;
    return ((addr % nbytes) != 0) || ((addr / 8) >= DEPTH);
  endfunction

  function automatic void model_store(input logic [63:0] addr, input logic [1:0] size,
                                      input logic [63:0] data);
    int nbytes = 1 << size;
    if (model_illegal(addr, size)) begin
      if (model_errs < 255) model_errs++;
      return;
    end
    for (int b = 0; b < nbytes; b++) begin
      int a = int'(addr) + b;
      model_mem[a / 8][(a % 8) * 8 +: 8]  = data[b * 8 +: 8];
      model_mask[a / 8][(a % 8) * 8 +: 8] = 8'hFF;
    end
  endfunction

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_store(input logic [63:0] addr, input logic [1:0] size,
                          input logic [63:0] data, input string tag);
    int guard = 0;
    bit bad;
    st_valid = 1'b1; st_addr = addr; st_size = size; st_data = data;
    while (!st_ready && guard < 200) begin
      mem_busy = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    if (!st_ready) begin
      n_vec++; n_err++;
      $display("FAIL %s ready_timeout: st_ready=%0b required 1", tag, st_ready);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    bad = model_illegal(addr, size);
    model_store(addr, size, data);
    n_vec++;
    if (st_err !== bad) begin
      n_err++;
      $display("FAIL %s st_err: got %0b required %0b", tag, st_err, bad);
    end
    n_vec++;
    if (err_cnt !== 8'(model_errs)) begin
      n_err++;
      $display("FAIL %s err_cnt: got %0d required %0d", tag, err_cnt, model_errs);
    end
    $display("store %s addr=0x%0h size=%0d data=0x%0h err=%0b", tag, addr, size, data, st_err);
  endtask

  task automatic wait_empty(input string tag);
    int guard = 0;
    while (empty !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    n_vec++;
    if (empty !== 1'b1) begin
      n_err++;
      $display("FAIL %s empty_timeout: empty=%0b required 1", tag, empty);
    end
  endtask

  task automatic check_word(input int idx, input string tag);
    logic [63:0] m;
    rd_en = 1'b1; rd_addr = AW'(idx);
    @(posedge clk); #1;
    rd_en = 1'b0;
    m = model_mask[idx];
    n_vec++;
    if ((rd_data & m) !== (model_mem[idx] & m)) begin
      n_err++;
      $display("FAIL %s word%0d: got 0x%016h required 0x%016h (mask 0x%016h)",
               tag, idx, rd_data, model_mem[idx], m);
    end else
      $display("read %s word%0d = 0x%016h", tag, idx, rd_data);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    mem_busy = 1'b0; rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_mask[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL reset st_ready: got %0b required 0", st_ready); end
    n_vec++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset empty: got %0b required 1", empty); end
    n_vec++; if (st_err !== 1'b0)   begin n_err++; $display("FAIL reset st_err: got %0b required 0", st_err); end
    n_vec++; if (err_cnt !== 8'd0)  begin n_err++; $display("FAIL reset err_cnt: got %0d required 0", err_cnt); end
    n_vec++; if (rd_data !== 64'd0) begin n_err++; $display("FAIL reset rd_data: got 0x%0h required 0", rd_data); end
    #2 rst_n = 1'b1;
    #1;
    n_vec++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL reset st_ready_pre_edge: got %0b required 0", st_ready); end
    @(posedge clk); #1;
    n_vec++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL reset st_ready_post_edge: got %0b required 1", st_ready); end
    $display("reset released, st_ready=%0b", st_ready);
  endtask

  task automatic test_full_word;
    logic [63:0] held;
    do_store(64'h10, 2'b11, 64'h1122334455667788, "sd_full");
    wait_empty("sd_full");
    check_word(2, "sd_full");
    held = rd_data;
    @(posedge clk); #1;
    n_vec++;
    if (rd_data !== held || held !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL rd_hold: got 0x%016h required 0x1122334455667788", rd_data);
    end
  endtask

  task automatic test_byte_merge;
    do_store(64'h13, 2'b00, 64'hAB, "sb_merge");
    wait_empty("sb_merge");
    check_word(2, "sb_merge");
    do_store(64'h16, 2'b01, 64'hBEEF, "sh_merge");
    wait_empty("sh_merge");
    check_word(2, "sh_merge");
    n_vec++;
    if (rd_data !== 64'hBEEF3344AB667788) begin
      n_err++;
      $display("FAIL merge_const: got 0x%016h required 0xBEEF3344AB667788", rd_data);
    end
  endtask

  task automatic test_misaligned;
    do_store(64'h20, 2'b11, 64'hCAFEF00D12345678, "sd_word4");
    wait_empty("sd_word4");
    do_store(64'h21, 2'b01, 64'h5555, "sh_misaligned");
    @(posedge clk); #1;
    n_vec++;
    if (st_err !== 1'b0) begin n_err++; $display("FAIL st_err_pulse_width: got %0b required 0", st_err); end
    wait_empty("sh_misaligned");
    check_word(4, "sh_misaligned");
    do_store(64'h100, 2'b10, 64'h77777777, "sw_oor");
    n_vec++;
    if (empty !== 1'b1) begin n_err++; $display("FAIL oor_enqueued: empty=%0b required 1", empty); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = {$urandom(), $urandom()};
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 64'h40 + 64'(i * 8); st_size = 2'b10; st_data = d[i];
      @(posedge clk); #1;
      model_store(st_addr, 2'b10, d[i]);
    end
    st_addr = 64'h60; st_data = d[4];
    n_vec++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL bp_full st_ready: got %0b required 0", st_ready); end
    n_vec++; if (empty !== 1'b0)    begin n_err++; $display("FAIL bp_full empty: got %0b required 0", empty); end
    @(posedge clk); #1;
    n_vec++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold st_ready: got %0b required 0", st_ready); end
    mem_busy = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL bp_after_pop st_ready: got %0b required 1", st_ready); end
    @(posedge clk); #1;
    st_valid = 1'b0;
    model_store(64'h60, 2'b10, d[4]);
    wait_empty("bp_drain");
    for (int i = 8; i < 13; i++) check_word(i, "bp_readback");
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      int          idx = $urandom_range(0, DEPTH + 3);
      int          nb = 1 << sz;
      int          off = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7)
                                                     : nb * $urandom_range(0, 8 / nb - 1);
      mem_busy = ($urandom_range(0, 2) == 0);
      do_store(64'(idx * 8 + off), sz, {$urandom(), $urandom()}, "rand");
    end
    mem_busy = 1'b0;
    wait_empty("rand");
    for (int i = 0; i < DEPTH; i++) check_word(i, "rand_final");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) do_store(64'(160 + i * 8), 2'b11, {$urandom(), $urandom()}, "pre_rst");
    wait_empty("pre_rst");
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 64'(160 + i * 8); st_size = 2'b11; st_data = ~64'(i);
      @(posedge clk); #1;
    end
    st_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_errs = 0;
    n_vec++; if (empty !== 1'b1)    begin n_err++; $display("FAIL midrst empty: got %0b required 1", empty); end
    n_vec++; if (err_cnt !== 8'd0)  begin n_err++; $display("FAIL midrst err_cnt: got %0d required 0", err_cnt); end
    n_vec++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL midrst st_ready: got %0b required 0", st_ready); end
    #3 rst_n = 1'b1;
    mem_busy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 20; i < 23; i++) check_word(i, "post_rst");
  endtask

  initial begin
    test_reset;
    test_full_word;
    test_byte_merge;
    test_misaligned;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
